// File: rtl/split_target_port_fifo.sv
// rtl/split_target_port_fifo.sv - split-transaction target port: TX FIFO + LSB-first serialiser, RX deserialiser
// Optional even-parity framing enabled by defining SPLIT_PORT_PARITY_EN.
module split_target_port_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int HALF_DUPLEX   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          target_data_out,
    input  logic                           target_data_out_valid,
    output logic                           target_data_out_ready,
    output logic [$clog2(TX_FIFO_DEPTH):0] tx_fifo_count,
    output logic                           bus_data_out,
    output logic                           bus_data_out_valid,
    input  logic                           bus_data_in,
    input  logic                           bus_data_in_valid,
    output logic [DATA_WIDTH-1:0]          target_data_in,
    output logic                           target_data_in_valid,
    input  logic                           split_req,
    output logic                           arbiter_split_req,
    input  logic                           arbiter_grant,
    output logic                           split_grant
`ifdef SPLIT_PORT_PARITY_EN
    ,
    output logic                           rx_parity_err
`endif
);

`ifdef SPLIT_PORT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FW = DATA_WIDTH + PAR;
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST    = BW'(FW - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GRANTED} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [TX_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop, fifo_empty, tx_permit, tx_busy, tx_last, rx_sample;
    logic [FW-1:0]         tx_frame, tx_shift, rx_shift, rx_next;
    logic [BW-1:0]         tx_cnt, rx_cnt;

    assign tx_busy               = bus_data_out_valid;
    assign fifo_empty            = (tx_fifo_count == '0);
    assign target_data_out_ready = (tx_fifo_count != DEPTH_C);
    assign push                  = target_data_out_valid && target_data_out_ready;
    assign tx_permit             = (state == IDLE && !split_req) || (state == GRANTED);
    assign tx_last               = tx_busy && (tx_cnt == LAST);
    assign pop                   = !fifo_empty && (!tx_busy || tx_last) && tx_permit;
    assign rx_sample             = bus_data_in_valid && !((HALF_DUPLEX != 0) && tx_busy);

`ifdef SPLIT_PORT_PARITY_EN
    assign tx_frame = {^mem[rd_ptr], mem[rd_ptr]};
`else
    assign tx_frame = mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= target_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   tx_fifo_count <= tx_fifo_count + (AW + 1)'(1);
                2'b01:   tx_fifo_count <= tx_fifo_count - (AW + 1)'(1);
                default: tx_fifo_count <= tx_fifo_count;
            endcase
        end
    end

    // A pop on the last bit reloads the shifter so consecutive frames run without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            tx_shift           <= '0;
            tx_cnt             <= '0;
        end else if (pop) begin
            bus_data_out       <= tx_frame[0];
            bus_data_out_valid <= 1'b1;
            tx_shift           <= tx_frame >> 1;
            tx_cnt             <= '0;
        end else if (tx_last) begin
            bus_data_out_valid <= 1'b0;
            tx_cnt             <= '0;
        end else if (tx_busy) begin
            bus_data_out <= tx_shift[0];
            tx_shift     <= tx_shift >> 1;
            tx_cnt       <= tx_cnt + BW'(1);
        end
    end

    always_comb begin
        rx_next = rx_shift;
        for (int i = 0; i < FW; i++) begin
            if (rx_cnt == BW'(i)) rx_next[i] = bus_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift             <= '0;
            rx_cnt               <= '0;
            target_data_in       <= '0;
            target_data_in_valid <= 1'b0;
`ifdef SPLIT_PORT_PARITY_EN
            rx_parity_err        <= 1'b0;
`endif
        end else begin
            target_data_in_valid <= 1'b0;
`ifdef SPLIT_PORT_PARITY_EN
            rx_parity_err        <= 1'b0;
`endif
            if (rx_sample) begin
                rx_shift <= rx_next;
                if (rx_cnt == LAST) begin
                    rx_cnt <= '0;
`ifdef SPLIT_PORT_PARITY_EN
                    if (^rx_next) begin
                        rx_parity_err <= 1'b1;
                    end else begin
                        target_data_in       <= rx_next[DATA_WIDTH-1:0];
                        target_data_in_valid <= 1'b1;
                    end
`else
                    target_data_in       <= rx_next[DATA_WIDTH-1:0];
                    target_data_in_valid <= 1'b1;
`endif
                end else begin
                    rx_cnt <= rx_cnt + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            arbiter_split_req <= 1'b0;
            split_grant       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (split_req && !fifo_empty) begin
                    state             <= REQ;
                    arbiter_split_req <= 1'b1;
                end
                REQ: if (!split_req) begin
                    state             <= IDLE;
                    arbiter_split_req <= 1'b0;
                end else if (arbiter_grant) begin
                    state       <= GRANTED;
                    split_grant <= 1'b1;
                end
                GRANTED: if (fifo_empty && !tx_busy) begin
                    state             <= IDLE;
                    arbiter_split_req <= 1'b0;
                    split_grant       <= 1'b0;
                end else if (!arbiter_grant) begin
                    state       <= REQ;
                    split_grant <= 1'b0;
                end
                default: begin
                    state             <= IDLE;
                    arbiter_split_req <= 1'b0;
                    split_grant       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_target_port_fifo.sv
// tb/tb_split_target_port_fifo.sv - directed bench for split_target_port_fifo (half- and full-duplex instances)
module tb_split_target_port_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] target_data_out;
    logic       target_data_out_valid;
    logic       bus_data_in, bus_data_in_valid;
    logic       split_req, arbiter_grant;

    logic       ready, bus_out, bus_valid, rx_valid, arb_req, sgrant;
    logic [2:0] count;
    logic [7:0] rx_data;
    logic       fd_ready, fd_bus_out, fd_bus_valid, fd_rx_valid, fd_arb_req, fd_sgrant;
    logic [2:0] fd_count;
    logic [7:0] fd_rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int hd_pulses = 0;
    int fd_pulses = 0;

    always #5 clk = ~clk;

    split_target_port_fifo #(.DATA_WIDTH(8), .TX_FIFO_DEPTH(4), .HALF_DUPLEX(1)) u_hd (
        .clk(clk), .rst(rst),
        .target_data_out(target_data_out), .target_data_out_valid(target_data_out_valid),
        .target_data_out_ready(ready), .tx_fifo_count(count),
        .bus_data_out(bus_out), .bus_data_out_valid(bus_valid),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .target_data_in(rx_data), .target_data_in_valid(rx_valid),
        .split_req(split_req), .arbiter_split_req(arb_req),
        .arbiter_grant(arbiter_grant), .split_grant(sgrant)
    );

    split_target_port_fifo #(.DATA_WIDTH(8), .TX_FIFO_DEPTH(4), .HALF_DUPLEX(0)) u_fd (
        .clk(clk), .rst(rst),
        .target_data_out(target_data_out), .target_data_out_valid(target_data_out_valid),
        .target_data_out_ready(fd_ready), .tx_fifo_count(fd_count),
        .bus_data_out(fd_bus_out), .bus_data_out_valid(fd_bus_valid),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .target_data_in(fd_rx_data), .target_data_in_valid(fd_rx_valid),
        .split_req(split_req), .arbiter_split_req(fd_arb_req),
        .arbiter_grant(arbiter_grant), .split_grant(fd_sgrant)
    );

    always @(negedge clk) begin
        if (rx_valid)    hd_pulses++;
        if (fd_rx_valid) fd_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        target_data_out       = w;
        target_data_out_valid = 1'b1;
        step();
        target_data_out_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            bus_data_in       = w[k];
            bus_data_in_valid = 1'b1;
            step();
        end
        bus_data_in_valid = 1'b0;
    endtask

    // tx_seq lists the expected serial bits in time order, first bit in tx_seq[7].
    typedef struct {
        logic [7:0] tx_word;
        logic [7:0] tx_seq;
        logic [7:0] rx_word;
        logic [7:0] rx_exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] got;
        logic [7:0]  seq;
        logic        all_valid;
        int          nb, gap_err, p_hd, p_fd;

        vecs[0] = '{8'hA5, 8'b1010_0101, 8'h3C, 8'h3C};
        vecs[1] = '{8'h01, 8'b1000_0000, 8'h81, 8'h81};
        vecs[2] = '{8'h80, 8'b0000_0001, 8'hFF, 8'hFF};
        vecs[3] = '{8'h6E, 8'b0111_0110, 8'h00, 8'h00};

        rst = 1'b1; target_data_out = '0; target_data_out_valid = 1'b0;
        bus_data_in = 1'b0; bus_data_in_valid = 1'b0; split_req = 1'b0; arbiter_grant = 1'b0;
        repeat (3) step();
        check("rst_ready", ready, 1);
        check("rst_count", count, 0);
        check("rst_bus", {bus_out, bus_valid}, 0);
        check("rst_rx", {rx_data, rx_valid}, 0);
        check("rst_split", {arb_req, sgrant}, 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            push_word(vecs[v].tx_word);
            check("tx_pre_valid", bus_valid, 0);
            all_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                seq[7-k]  = bus_out;
                all_valid = all_valid & bus_valid;
            end
            check("tx_bits", seq, vecs[v].tx_seq);
            check("tx_valid_8", all_valid, 1);
            step();
            check("tx_end", bus_valid, 0);
            p_hd = hd_pulses;
            send_rx(vecs[v].rx_word);
            check("rx_valid", rx_valid, 1);
            check("rx_data", rx_data, vecs[v].rx_exp);
            step();
            check("rx_pulse_once", hd_pulses - p_hd, 1);
            check("rx_hold", rx_data, vecs[v].rx_exp);
        end

        // Fill FIFO while split request blocks TX, then grant.
        split_req = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'h11 * (i + 1));
        check("full_count", count, 4);
        check("full_ready", ready, 0);
        check("full_req", {arb_req, sgrant}, 2'b10);
        step();
        check("blocked_tx", bus_valid, 0);
        arbiter_grant = 1'b1;
        step();
        check("granted", sgrant, 1);
        got = '0; nb = 0; gap_err = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus_valid) begin
                if (nb < 32) got[nb] = bus_out;
                nb++;
                if (!arb_req || !sgrant) gap_err++;
            end else if (nb > 0 && nb < 32) begin
                gap_err++;
            end
        end
        check("split_nbits", nb, 32);
        check("split_data", got, 32'h44332211);
        check("split_gapless", gap_err, 0);
        check("split_idle", {arb_req, sgrant}, 0);
        check("split_empty", {ready, count}, 4'b1000);
        split_req = 1'b0; arbiter_grant = 1'b0;
        step();

        // Grant withdrawn mid second word.
        split_req = 1'b1;
        push_word(8'hA1); push_word(8'hB2); push_word(8'hC3);
        arbiter_grant = 1'b1;
        got = '0; nb = 0;
        for (int c = 0; c < 30 && nb < 10; c++) begin
            step();
            if (bus_valid) begin got[nb] = bus_out; nb++; end
        end
        check("drop_reach", nb, 10);
        arbiter_grant = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus_valid && nb < 32) begin got[nb] = bus_out; nb++; end
        end
        check("drop_word2_done", nb, 16);
        check("drop_state_req", {arb_req, sgrant}, 2'b10);
        check("drop_count", count, 1);
        arbiter_grant = 1'b1;
        step();
        check("regrant", sgrant, 1);
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus_valid && nb < 32) begin got[nb] = bus_out; nb++; end
        end
        check("regrant_nbits", nb, 24);
        check("regrant_data", got[23:0], 24'hC3B2A1);
        check("regrant_idle", {arb_req, sgrant}, 0);
        split_req = 1'b0; arbiter_grant = 1'b0;
        step();

        // RX bits arriving while TX is busy.
        push_word(8'h00);
        step();
        check("hd_tx_busy", bus_valid, 1);
        for (int k = 0; k < 3; k++) begin
            bus_data_in = 1'b1; bus_data_in_valid = 1'b1;
            step();
        end
        bus_data_in_valid = 1'b0;
        repeat (8) step();
        p_hd = hd_pulses; p_fd = fd_pulses;
        send_rx(8'h5A);
        step();
        check("hd_data", rx_data, 8'h5A);
        check("hd_pulses", hd_pulses - p_hd, 1);
        check("fd_data", fd_rx_data, 8'hD7);
        check("fd_pulses", fd_pulses - p_fd, 1);

        // Reset with partial RX word and TX word in flight.
        for (int k = 0; k < 3; k++) begin
            bus_data_in = 1'b1; bus_data_in_valid = 1'b1;
            step();
        end
        bus_data_in_valid = 1'b0;
        push_word(8'hFF);
        push_word(8'h0F);
        repeat (3) step();
        check("pre_rst_busy", bus_valid, 1);
        p_hd = hd_pulses;
        rst = 1'b1;
        step();
        check("mid_rst_bus", {bus_out, bus_valid}, 0);
        check("mid_rst_fifo", {ready, count}, 4'b1000);
        check("mid_rst_rx", {rx_data, rx_valid}, 0);
        check("mid_rst_fd_rx", fd_rx_data, 0);
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_no_tx", bus_valid, 0);
        send_rx(8'h96);
        check("post_rst_rx", {rx_valid, rx_data}, 9'h196);
        check("post_rst_fd_rx", fd_rx_data, 8'h96);
        step();
        check("post_rst_pulses", hd_pulses - p_hd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
